i2s_tdm_rx_mc: RTL and testbench

//  Parametrised multi-lane, multi-slot TDM/I2S slave receiver. It runs entirely in the

---
 rtl/i2s_tdm_rx_mc.sv | 212 +++++++++++++++++++++
 tb/tb_i2s_tdm_rx_mc.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tdm_rx_mc.sv
// Multi-lane TDM/I2S slave receiver: SCK/WS/SD are oversampled in the clk_i domain and
// every completed slot word (all lanes together) becomes one entry of a valid/ready FIFO.
module i2s_tdm_rx_mc #(
  parameter int N_LANES    = 2,
  parameter int N_SLOTS    = 8,
  parameter int MAX_WLEN   = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        pad_sck_i,
  input  logic                        pad_ws_i,
  input  logic [N_LANES-1:0]          pad_sd_i,
  input  logic                        cfg_en_i,
  input  logic [$clog2(N_SLOTS)-1:0]  cfg_nslots_i,
  input  logic [$clog2(MAX_WLEN)-1:0] cfg_wlen_i,
  input  logic                        cfg_lsb_first_i,
  input  logic                        cfg_delay_i,
  input  logic                        cfg_clr_i,
  output logic [N_LANES*MAX_WLEN-1:0] data_o,
  output logic [$clog2(N_SLOTS)-1:0]  data_slot_o,
  output logic                        data_valid_o,
  input  logic                        data_ready_i,
  output logic                        overflow_o,
  output logic                        frame_err_o
);
  localparam int SW = $clog2(N_SLOTS);
  localparam int WW = $clog2(MAX_WLEN);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int DW = N_LANES * MAX_WLEN;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT_FS, ST_RECV} state_t;

  logic sck_meta_q, sck_meta_d, sck_sync_q, sck_sync_d, sck_dly_q, sck_dly_d;
  logic ws_meta_q, ws_meta_d, ws_sync_q, ws_sync_d, ws_prev_q, ws_prev_d;
  logic [N_LANES-1:0] sd_meta_q, sd_meta_d, sd_sync_q, sd_sync_d;
  state_t state_q, state_d;
  logic [WW-1:0] bit_q, bit_d;
  logic [SW-1:0] slot_q, slot_d;
  logic [N_LANES-1:0][MAX_WLEN-1:0] shreg_q, shreg_d;
  logic push_q, push_d;
  logic [SW-1:0] push_slot_q, push_slot_d;
  logic [DW-1:0] mem_q [FIFO_DEPTH];
  logic [DW-1:0] mem_d [FIFO_DEPTH];
  logic [SW-1:0] mslot_q [FIFO_DEPTH];
  logic [SW-1:0] mslot_d [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0] count_q, count_d;
  logic overflow_q, overflow_d, frame_err_q, frame_err_d;
  logic sck_rise, ws_rise, sample, last_bit, pop, full, wr_en;
  logic [MAX_WLEN-1:0] base;

  // Pad synchronisers, edge detection and the slot/bit sequencer.
  always_comb begin
    sck_meta_d  = pad_sck_i;
    sck_sync_d  = sck_meta_q;
    sck_dly_d   = sck_sync_q;
    ws_meta_d   = pad_ws_i;
    ws_sync_d   = ws_meta_q;
    sd_meta_d   = pad_sd_i;
    sd_sync_d   = sd_meta_q;
    sck_rise    = sck_sync_q & ~sck_dly_q;
    ws_rise     = sck_rise & ws_sync_q & ~ws_prev_q;
    ws_prev_d   = sck_rise ? ws_sync_q : ws_prev_q;
    last_bit    = (bit_q == cfg_wlen_i) && (slot_q == cfg_nslots_i);
    state_d     = state_q;
    bit_d       = bit_q;
    slot_d      = slot_q;
    shreg_d     = shreg_q;
    push_d      = 1'b0;
    push_slot_d = push_slot_q;
    sample      = 1'b0;
    base        = '0;
    frame_err_d = cfg_clr_i ? 1'b0 : frame_err_q;

    if (!cfg_en_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_WAIT_FS;
        ST_WAIT_FS: begin
          if (ws_rise) begin
            state_d = ST_RECV;
            slot_d  = '0;
            bit_d   = '0;
            sample  = ~cfg_delay_i;
          end
        end
        ST_RECV: begin
          if (ws_rise && !last_bit) begin
            frame_err_d = 1'b1;
            slot_d      = '0;
            bit_d       = '0;
            sample      = ~cfg_delay_i;
          end else if (sck_rise) begin
            sample = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (sample) begin
      // Bit 0 starts from a clean word so upper bits stay zero for short words.
      for (int l = 0; l < N_LANES; l++) begin
        base = (bit_d == '0) ? '0 : shreg_q[l];
        if (cfg_lsb_first_i) begin
          shreg_d[l]        = base;
          shreg_d[l][bit_d] = sd_sync_q[l];
        end else begin
          shreg_d[l] = {base[MAX_WLEN-2:0], sd_sync_q[l]};
        end
      end
      if (bit_d == cfg_wlen_i) begin
        push_d      = 1'b1;
        push_slot_d = slot_d;
        bit_d       = '0;
        if (slot_d == cfg_nslots_i) begin
          slot_d  = '0;
          state_d = ST_WAIT_FS;
        end else begin
          slot_d = slot_d + 1'b1;
        end
      end else begin
        bit_d = bit_d + 1'b1;
      end
    end
  end

  // Output FIFO: registered valid, no bypass; a full FIFO still accepts when popping.
  always_comb begin
    mem_d    = mem_q;
    mslot_d  = mslot_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    pop      = (count_q != '0) & data_ready_i;
    full     = (count_q == FULL_CNT);
    wr_en    = push_q & (~full | pop);
    overflow_d = cfg_clr_i ? 1'b0 : overflow_q;
    if (push_q && full && !pop) overflow_d = 1'b1;
    if (wr_en) begin
      mem_d[wr_ptr_q]   = shreg_q;
      mslot_d[wr_ptr_q] = push_slot_q;
      wr_ptr_d          = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sck_meta_q  <= 1'b0;
      sck_sync_q  <= 1'b0;
      sck_dly_q   <= 1'b0;
      ws_meta_q   <= 1'b0;
      ws_sync_q   <= 1'b0;
      ws_prev_q   <= 1'b0;
      sd_meta_q   <= '0;
      sd_sync_q   <= '0;
      state_q     <= ST_IDLE;
      bit_q       <= '0;
      slot_q      <= '0;
      shreg_q     <= '0;
      push_q      <= 1'b0;
      push_slot_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i]   <= '0;
        mslot_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sck_meta_q  <= sck_meta_d;
      sck_sync_q  <= sck_sync_d;
      sck_dly_q   <= sck_dly_d;
      ws_meta_q   <= ws_meta_d;
      ws_sync_q   <= ws_sync_d;
      ws_prev_q   <= ws_prev_d;
      sd_meta_q   <= sd_meta_d;
      sd_sync_q   <= sd_sync_d;
      state_q     <= state_d;
      bit_q       <= bit_d;
      slot_q      <= slot_d;
      shreg_q     <= shreg_d;
      push_q      <= push_d;
      push_slot_q <= push_slot_d;
      mem_q       <= mem_d;
      mslot_q     <= mslot_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign data_o       = mem_q[rd_ptr_q];
  assign data_slot_o  = mslot_q[rd_ptr_q];
  assign data_valid_o = (count_q != '0);
  assign overflow_o   = overflow_q;
  assign frame_err_o  = frame_err_q;

endmodule

// File: tb/tb_i2s_tdm_rx_mc.sv
// Bench for i2s_tdm_rx_mc: a table of frame vectors, hand-built corner sequences and
// random frames, all checked against a frame-level expectation queue.
`timescale 1ns/1ps
module tb_i2s_tdm_rx_mc;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        pad_sck_i, pad_ws_i;
  logic [1:0]  pad_sd_i;
  logic        cfg_en_i, cfg_lsb_first_i, cfg_delay_i, cfg_clr_i;
  logic [2:0]  cfg_nslots_i;
  logic [4:0]  cfg_wlen_i;
  logic [63:0] data_o;
  logic [2:0]  data_slot_o;
  logic        data_valid_o, data_ready_i, overflow_o, frame_err_o;

  always #5 clk_i = ~clk_i;

  i2s_tdm_rx_mc dut (
    .clk_i(clk_i), .rst_i(rst_i), .pad_sck_i(pad_sck_i), .pad_ws_i(pad_ws_i),
    .pad_sd_i(pad_sd_i), .cfg_en_i(cfg_en_i), .cfg_nslots_i(cfg_nslots_i),
    .cfg_wlen_i(cfg_wlen_i), .cfg_lsb_first_i(cfg_lsb_first_i), .cfg_delay_i(cfg_delay_i),
    .cfg_clr_i(cfg_clr_i), .data_o(data_o), .data_slot_o(data_slot_o),
    .data_valid_o(data_valid_o), .data_ready_i(data_ready_i),
    .overflow_o(overflow_o), .frame_err_o(frame_err_o)
  );

  typedef struct { logic [63:0] data; logic [2:0] slot; } exp_t;
  typedef struct {
    int wl; int ns; bit lsb; bit dly;
    logic [31:0] w0; logic [31:0] w1; logic [31:0] e0; logic [31:0] e1;
  } vec_t;

  exp_t        exp_q[$];
  vec_t        vecs[5];
  logic [31:0] fr_w [2][8];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          rdy_mode = 0;
  bit          force_rdy = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Consumer: sets ready, then scores the head that will be popped at the next posedge.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk_i);
      data_ready_i = force_rdy | (rdy_mode == 1) | (rdy_mode == 2 && $urandom_range(0, 1) == 1);
      if (data_valid_o && data_ready_i) begin
        if (exp_q.size() == 0) begin
          check("unexpected_entry", data_o, 64'hx);
        end else begin
          e = exp_q.pop_front();
          check("entry_data", data_o, e.data);
          check("entry_slot", 64'(data_slot_o), 64'(e.slot));
        end
      end
    end
  endtask

  task automatic sck_bit(input logic ws, input logic [1:0] sd);
    @(negedge clk_i);
    pad_sck_i = 1'b0; pad_ws_i = ws; pad_sd_i = sd;
    repeat (3) @(negedge clk_i);
    pad_sck_i = 1'b1;
    repeat (4) @(negedge clk_i);
  endtask

  function automatic logic [1:0] bit_of(input int s, input int i);
    int idx;
    logic [31:0] a, b;
    idx = cfg_lsb_first_i ? i : (int'(cfg_wlen_i) - i);
    a = fr_w[0][s];
    b = fr_w[1][s];
    return {b[idx], a[idx]};
  endfunction

  // Sends one frame from fr_w; max_bits >= 0 stops after that many data bits.
  task automatic send_frame(input int max_bits);
    int n = 0;
    if (cfg_delay_i) sck_bit(1'b1, 2'($urandom_range(0, 3)));
    for (int s = 0; s <= int'(cfg_nslots_i); s++) begin
      for (int i = 0; i <= int'(cfg_wlen_i); i++) begin
        if (max_bits >= 0 && n >= max_bits) return;
        sck_bit(!cfg_delay_i && n == 0, bit_of(s, i));
        n++;
      end
    end
  endtask

  task automatic expect_words(input int nwords);
    exp_t e;
    logic [31:0] m;
    m = (cfg_wlen_i == 5'd31) ? 32'hFFFF_FFFF : ((32'd1 << (int'(cfg_wlen_i) + 1)) - 32'd1);
    for (int s = 0; s < nwords; s++) begin
      e.data = {fr_w[1][s] & m, fr_w[0][s] & m};
      e.slot = 3'(s);
      exp_q.push_back(e);
    end
  endtask

  task automatic fill_random();
    for (int l = 0; l < 2; l++)
      for (int s = 0; s < 8; s++) fr_w[l][s] = $urandom();
  endtask

  task automatic setcfg(input int ns, input int wl, input bit lsb, input bit dly);
    @(negedge clk_i); cfg_en_i = 1'b0;
    @(negedge clk_i);
    cfg_nslots_i = 3'(ns); cfg_wlen_i = 5'(wl); cfg_lsb_first_i = lsb; cfg_delay_i = dly;
    @(negedge clk_i); cfg_en_i = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic wait_drain(input string name);
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < 4000) begin
      @(negedge clk_i); cyc++;
    end
    check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    repeat (3) @(negedge clk_i);
    check({name, "_no_extra"}, 64'(data_valid_o), 64'd0);
  endtask

  task automatic pulse_clr();
    @(negedge clk_i); cfg_clr_i = 1'b1;
    @(negedge clk_i); cfg_clr_i = 1'b0;
  endtask

  initial begin
    vec_t v;
    vecs[0] = '{15, 1, 1'b0, 1'b1, 32'h0000A5C3, 32'h00001234, 32'h0000A5C3, 32'h00001234};
    vecs[1] = '{23, 0, 1'b1, 1'b0, 32'h00800001, 32'hFFFFFFFF, 32'h00800001, 32'h00FFFFFF};
    vecs[2] = '{ 7, 3, 1'b0, 1'b0, 32'h12345696, 32'h0000005A, 32'h00000096, 32'h0000005A};
    vecs[3] = '{31, 0, 1'b1, 1'b1, 32'hDEADBEEF, 32'h0F0F1234, 32'hDEADBEEF, 32'h0F0F1234};
    vecs[4] = '{ 4, 2, 1'b0, 1'b1, 32'h00000013, 32'hFFFFFFEA, 32'h00000013, 32'h0000000A};

    rst_i = 1'b1; pad_sck_i = 1'b0; pad_ws_i = 1'b0; pad_sd_i = 2'b00;
    cfg_en_i = 1'b0; cfg_nslots_i = '0; cfg_wlen_i = '0; cfg_lsb_first_i = 1'b0;
    cfg_delay_i = 1'b0; cfg_clr_i = 1'b0; data_ready_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("rst_valid", 64'(data_valid_o), 64'd0);
    check("rst_data", data_o, 64'd0);
    check("rst_slot", 64'(data_slot_o), 64'd0);
    check("rst_overflow", 64'(overflow_o), 64'd0);
    check("rst_frame_err", 64'(frame_err_o), 64'd0);
    rst_i = 1'b0;
    fork monitor(); join_none

    // Table of single frames with fixed words.
    rdy_mode = 1;
    for (int k = 0; k < 5; k++) begin
      v = vecs[k];
      setcfg(v.ns, v.wl, v.lsb, v.dly);
      for (int s = 0; s < 8; s++) begin fr_w[0][s] = v.w0; fr_w[1][s] = v.w1; end
      for (int s = 0; s <= v.ns; s++) exp_q.push_back('{ {v.e1, v.e0}, 3'(s) });
      send_frame(-1);
      wait_drain($sformatf("vec%0d", k));
      check($sformatf("vec%0d_overflow", k), 64'(overflow_o), 64'd0);
      check($sformatf("vec%0d_frame_err", k), 64'(frame_err_o), 64'd0);
    end

    // Latency: valid must rise exactly on the 4th clock after the last-bit SCK pad rise.
    rdy_mode = 0;
    setcfg(0, 23, 1'b1, 1'b0);
    fr_w[0][0] = 32'h00800001; fr_w[1][0] = $urandom();
    send_frame(23);
    @(negedge clk_i);
    pad_sck_i = 1'b0; pad_ws_i = 1'b0; pad_sd_i = bit_of(0, 23);
    repeat (3) @(negedge clk_i);
    pad_sck_i = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk_i);
      check($sformatf("latency_valid_c%0d", c), 64'(data_valid_o), 64'(c == 4));
    end
    check("latency_lane0", 64'(data_o[31:0]), 64'h00800001);
    expect_words(1);
    rdy_mode = 1;
    wait_drain("latency");

    // Overflow: 8 frames of 8 slots against a stalled consumer.
    rdy_mode = 0;
    setcfg(7, 7, 1'b0, 1'b1);
    for (int f = 0; f < 8; f++) begin
      fill_random();
      if (f == 0) expect_words(4);
      send_frame(-1);
    end
    check("ovf_flag", 64'(overflow_o), 64'd1);
    check("ovf_valid", 64'(data_valid_o), 64'd1);
    check("ovf_head_data", data_o, exp_q[0].data);
    check("ovf_head_slot", 64'(data_slot_o), 64'd0);
    pulse_clr();
    check("ovf_cleared", 64'(overflow_o), 64'd0);
    rdy_mode = 1;
    wait_drain("ovf");

    // Full FIFO popped in the same cycle the fifth word is written.
    rdy_mode = 0;
    setcfg(4, 7, 1'b0, 1'b0);
    fill_random();
    expect_words(5);
    send_frame(39);
    @(negedge clk_i);
    pad_sck_i = 1'b0; pad_ws_i = 1'b0; pad_sd_i = bit_of(4, 7);
    repeat (3) @(negedge clk_i);
    pad_sck_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1 force_rdy = 1'b1;
    @(posedge clk_i);
    #1 force_rdy = 1'b0;
    repeat (2) @(negedge clk_i);
    check("fullpop_overflow", 64'(overflow_o), 64'd0);
    check("fullpop_remaining", 64'(exp_q.size()), 64'd4);
    rdy_mode = 1;
    wait_drain("fullpop");

    // WS rise at slot 2 bit 5 aborts the frame; a clean frame follows.
    setcfg(3, 15, 1'b0, 1'b1);
    fill_random();
    expect_words(2);
    send_frame(37);
    fill_random();
    expect_words(4);
    send_frame(-1);
    wait_drain("abort");
    check("abort_frame_err", 64'(frame_err_o), 64'd1);

    // Enable dropped mid-word, then a full frame.
    pulse_clr();
    check("clr_frame_err", 64'(frame_err_o), 64'd0);
    setcfg(1, 15, 1'b0, 1'b1);
    fill_random();
    send_frame(10);
    @(negedge clk_i); cfg_en_i = 1'b0;
    repeat (3) @(negedge clk_i); cfg_en_i = 1'b1;
    fill_random();
    expect_words(2);
    send_frame(-1);
    wait_drain("endrop");
    check("endrop_frame_err", 64'(frame_err_o), 64'd0);

    // Reset in the middle of a frame with entries held and a flag set.
    rdy_mode = 0;
    setcfg(1, 7, 1'b0, 1'b1);
    fill_random();
    send_frame(-1);
    send_frame(5);
    send_frame(3);
    check("prerst_valid", 64'(data_valid_o), 64'd1);
    check("prerst_frame_err", 64'(frame_err_o), 64'd1);
    @(negedge clk_i); rst_i = 1'b1;
    @(negedge clk_i);
    check("midrst_valid", 64'(data_valid_o), 64'd0);
    check("midrst_frame_err", 64'(frame_err_o), 64'd0);
    check("midrst_overflow", 64'(overflow_o), 64'd0);
    check("midrst_data", data_o, 64'd0);
    rst_i = 1'b0;

    // Random configurations and words with a random-ready consumer.
    rdy_mode = 2;
    for (int r = 0; r < 6; r++) begin
      setcfg($urandom_range(0, 3), $urandom_range(3, 31), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)));
      fill_random();
      expect_words(int'(cfg_nslots_i) + 1);
      send_frame(-1);
    end
    wait_drain("random");
    check("random_overflow", 64'(overflow_o), 64'd0);
    check("random_frame_err", 64'(frame_err_o), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
